ysyx_23060236_rd_arbiter: RTL and testbench
===========================================

// Module: ysyx_23060236_rd_arbiter
// PURPOSE
//  Read-channel arbiter/router. Shares one outstanding AXI-lite read between two masters
//  (m0 = IFU, m1 = LSU) and steers it to one of two slaves: CLINT (mtime window) or MEM.
//  Sits between the core fetch/load units and the CLINT + memory read ports.
//  One transaction in flight; round-robin grant; address-decoded slave select.
// PARAMETERS
//  CLINT_BASE  32'ha000_0048  first byte address routed to the CLINT slave
//  CLINT_SIZE  32'h0000_0008  window size in bytes (mtime lo/hi words)
// PORTS
//  clock                 in   1   single clock, all state on posedge
//  reset                 in   1   synchronous, active-high
//  mN_araddr             in   32  master N read address (N = 0,1)
//  mN_arvalid            in   1   master N AR request
//  mN_arready            out  1   master N AR accepted
//  mN_rdata / mN_rresp   out  32/2  read data / response returned to master N
//  mN_rvalid             out  1   read data valid to master N
//  mN_rready             in   1   master N accepts read data
//  sK_araddr             out  32  slave K address (K: c = CLINT, m = MEM)
//  sK_arvalid            out  1   slave K AR request
//  sK_arready            in   1   slave K AR accepted
//  sK_rdata / sK_rresp   in   32/2  slave K read data / response
//  sK_rvalid             in   1   slave K data valid
//  sK_rready             out  1   forwarded master rready
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=1 (so m0 wins first tie); all valid/ready outputs 0,
//   sK_araddr 0, mN_rdata 0, mN_rresp 0.
//  FSM IDLE -> ADDR -> DATA -> IDLE.
//  IDLE: if any mN_arvalid, pick winner: single requester wins; both -> the one != last_grant.
//   Latch winner's araddr into addr_q, winner into gnt_q, slave select into sel_q
//   (sel_q=CLINT iff CLINT_BASE <= addr < CLINT_BASE+CLINT_SIZE, unsigned 32-bit, else MEM);
//   update last_grant=winner; go ADDR. No master handshake occurs in IDLE.
//  ADDR: sel slave sees sK_arvalid=1, sK_araddr=addr_q; other slave arvalid=0.
//   mN_arready(gnt_q) = sK_arready(sel_q) combinationally; loser arready=0.
//   On sK_arvalid&sK_arready -> DATA. Winner must hold arvalid/araddr until then (AXI rule).
//  DATA: sK_rready(sel_q) = mN_rready(gnt_q); mN_rvalid(gnt_q)=sK_rvalid(sel_q);
//   mN_rdata/rresp pass through from selected slave; non-granted master rvalid=0,
//   non-selected slave rready=0. On rvalid&rready -> IDLE.
//  Latency: min 3 cycles request-to-data (1 arbitration + slave AR + slave R); no new
//   grant in the cycle DATA completes (returns to IDLE first).
//  Non-winning master's arvalid is held pending, never dropped; granted next IDLE (fairness).
//  Slave rresp forwarded unmodified; arbiter never generates errors.
//  Address exactly CLINT_BASE+CLINT_SIZE routes to MEM; top-of-space wrap must not alias.
//  Reset mid-transaction: immediate return to IDLE, outstanding beat discarded.
//  At most one of sc_arvalid/sm_arvalid and one of m0_rvalid/m1_rvalid high per cycle.
// TESTING
//  1. m0 only, addr 8000_0000, MEM arready after 2 cyc, rdata 1234_5678 -> m0 gets it, sc idle.
//  2. m1 only, addr a000_004c -> sc_araddr=a000_004c, m1_rdata=CLINT hi word, sm idle.
//  3. m0+m1 request same cycle after reset -> m0 served first, then m1; repeat -> alternates.
//  4. m1 addr a000_0050 (window end) -> routed to MEM; a000_0047 -> MEM.
//  5. m0_rready low 5 cycles in DATA -> m0_rvalid/rdata held stable, sm_rready low.
//  6. reset asserted in ADDR/DATA -> next cycle all valids 0, IDLE; new request serviced.

Source files
------------

// File: rtl/ysyx_23060236_rd_arbiter_if.sv
// ysyx_23060236_rd_arbiter_if: AXI-lite read channel bundle (AR + R)
interface ysyx_23060236_rd_arbiter_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  modport master (output araddr, arvalid, rready, input arready, rdata, rresp, rvalid);
  modport slave  (input araddr, arvalid, rready, output arready, rdata, rresp, rvalid);
endinterface

// File: rtl/ysyx_23060236_rd_arbiter.sv
// ysyx_23060236_rd_arbiter: round-robin 2-master read arbiter routing to CLINT or MEM
module ysyx_23060236_rd_arbiter #(
  parameter logic [31:0] CLINT_BASE = 32'ha000_0048,
  parameter logic [31:0] CLINT_SIZE = 32'h0000_0008
) (
  input  logic                              clock,
  input  logic                              reset,
  ysyx_23060236_rd_arbiter_if.slave  m0,
  ysyx_23060236_rd_arbiter_if.slave  m1,
  ysyx_23060236_rd_arbiter_if.master sc,
  ysyx_23060236_rd_arbiter_if.master sm
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;
  state_e      state_q;
  logic        last_q, gnt_q, sel_q;
  logic [31:0] addr_q;
  logic        win_d, sel_d, ar_rdy, r_vld, r_rdy, in_addr, in_data;
  logic [31:0] addr_d, r_data;
  logic [1:0]  r_resp;
  always_comb begin
    win_d   = (m0.arvalid & m1.arvalid) ? ~last_q : m1.arvalid;
    addr_d  = win_d ? m1.araddr : m0.araddr;
    // offset compare keeps the window from aliasing across the top of the address space
    sel_d   = (addr_d >= CLINT_BASE) && ((addr_d - CLINT_BASE) < CLINT_SIZE);
    in_addr = state_q == ADDR;
    in_data = state_q == DATA;
    ar_rdy  = sel_q ? sc.arready : sm.arready;
    r_vld   = sel_q ? sc.rvalid : sm.rvalid;
    r_data  = sel_q ? sc.rdata : sm.rdata;
    r_resp  = sel_q ? sc.rresp : sm.rresp;
    r_rdy   = gnt_q ? m1.rready : m0.rready;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      sel_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (m0.arvalid | m1.arvalid) begin
          gnt_q   <= win_d;
          last_q  <= win_d;
          sel_q   <= sel_d;
          addr_q  <= addr_d;
          state_q <= ADDR;
        end
        ADDR: if (ar_rdy) state_q <= DATA;
        DATA: if (r_vld & r_rdy) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign sc.arvalid = in_addr & sel_q;
  assign sm.arvalid = in_addr & ~sel_q;
  assign sc.araddr  = (in_addr & sel_q) ? addr_q : '0;
  assign sm.araddr  = (in_addr & ~sel_q) ? addr_q : '0;
  assign sc.rready  = in_data & sel_q & r_rdy;
  assign sm.rready  = in_data & ~sel_q & r_rdy;
  assign m0.arready = in_addr & ~gnt_q & ar_rdy;
  assign m1.arready = in_addr & gnt_q & ar_rdy;
  assign m0.rvalid  = in_data & ~gnt_q & r_vld;
  assign m1.rvalid  = in_data & gnt_q & r_vld;
  assign m0.rdata   = (in_data & ~gnt_q) ? r_data : '0;
  assign m1.rdata   = (in_data & gnt_q) ? r_data : '0;
  assign m0.rresp   = (in_data & ~gnt_q) ? r_resp : '0;
  assign m1.rresp   = (in_data & gnt_q) ? r_resp : '0;
endmodule

// File: tb/tb_ysyx_23060236_rd_arbiter.sv
// tb_ysyx_23060236_rd_arbiter: directed self-checking bench for the read arbiter
module tb_ysyx_23060236_rd_arbiter;
  logic clock = 1'b0, reset = 1'b1;
  int checks = 0, errors = 0;
  always #5 clock = ~clock;
  ysyx_23060236_rd_arbiter_if m0 ();
  ysyx_23060236_rd_arbiter_if m1 ();
  ysyx_23060236_rd_arbiter_if sc ();
  ysyx_23060236_rd_arbiter_if sm ();
  ysyx_23060236_rd_arbiter dut (.clock(clock), .reset(reset), .m0(m0), .m1(m1), .sc(sc), .sm(sm));
  // index 0/1 = m0/m1 for masters, CLINT/MEM for slaves
  logic [31:0] m_araddr [2];
  logic        m_arvalid[2], m_rready[2];
  logic        s_arready[2], s_rvalid[2];
  logic [31:0] s_rdata  [2];
  logic [1:0]  s_rresp  [2];
  logic        m_arready[2], m_rvalid[2], s_arvalid[2], s_rready[2];
  logic [31:0] m_rdata  [2], s_araddr[2];
  logic [1:0]  m_rresp  [2];
  assign m0.araddr = m_araddr[0];  assign m1.araddr = m_araddr[1];
  assign m0.arvalid = m_arvalid[0]; assign m1.arvalid = m_arvalid[1];
  assign m0.rready = m_rready[0];  assign m1.rready = m_rready[1];
  assign sc.arready = s_arready[0]; assign sm.arready = s_arready[1];
  assign sc.rvalid = s_rvalid[0];  assign sm.rvalid = s_rvalid[1];
  assign sc.rdata = s_rdata[0];    assign sm.rdata = s_rdata[1];
  assign sc.rresp = s_rresp[0];    assign sm.rresp = s_rresp[1];
  assign m_arready[0] = m0.arready; assign m_arready[1] = m1.arready;
  assign m_rvalid[0] = m0.rvalid;   assign m_rvalid[1] = m1.rvalid;
  assign m_rdata[0] = m0.rdata;     assign m_rdata[1] = m1.rdata;
  assign m_rresp[0] = m0.rresp;     assign m_rresp[1] = m1.rresp;
  assign s_arvalid[0] = sc.arvalid; assign s_arvalid[1] = sm.arvalid;
  assign s_araddr[0] = sc.araddr;   assign s_araddr[1] = sm.araddr;
  assign s_rready[0] = sc.rready;   assign s_rready[1] = sm.rready;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      m_araddr[i] = '0; m_arvalid[i] = 0; m_rready[i] = 0;
      s_arready[i] = 0; s_rvalid[i] = 0; s_rdata[i] = '0; s_rresp[i] = '0;
    end
  endtask
  task automatic do_reset();
    reset = 1;
    clear_inputs();
    step();
    step();
    reset = 0;
  endtask
  task automatic request(input int g, input logic [31:0] a);
    m_araddr[g] = a;
    m_arvalid[g] = 1;
  endtask
  // Expects the arbiter in ADDR with master g granted towards slave k; completes the beat.
  task automatic serve(input int g, input int k, input logic [31:0] d, input logic [1:0] r,
                       input int aw, input int rw);
    int o = 1 - g;
    int ko = 1 - k;
    chk("sel_arvalid", 32'(s_arvalid[k]), 1);
    chk("oth_arvalid", 32'(s_arvalid[ko]), 0);
    chk("sel_araddr", s_araddr[k], m_araddr[g]);
    repeat (aw) begin
      chk("arready_wait", 32'(m_arready[g]), 0);
      step();
      chk("arvalid_hold", 32'(s_arvalid[k]), 1);
    end
    s_arready[k] = 1;
    #1;
    chk("gnt_arready", 32'(m_arready[g]), 1);
    chk("loser_arready", 32'(m_arready[o]), 0);
    step();
    m_arvalid[g] = 0;
    s_arready[k] = 0;
    chk("data_no_arvalid", 32'(s_arvalid[k]), 0);
    s_rvalid[k] = 1; s_rdata[k] = d; s_rresp[k] = r;
    #1;
    repeat (rw) begin
      chk("stall_rvalid", 32'(m_rvalid[g]), 1);
      chk("stall_rdata", m_rdata[g], d);
      chk("stall_rready", 32'(s_rready[k]), 0);
      step();
    end
    m_rready[g] = 1;
    #1;
    chk("rvalid", 32'(m_rvalid[g]), 1);
    chk("rdata", m_rdata[g], d);
    chk("rresp", 32'(m_rresp[g]), 32'(r));
    chk("oth_rvalid", 32'(m_rvalid[o]), 0);
    chk("sel_rready", 32'(s_rready[k]), 1);
    chk("oth_rready", 32'(s_rready[ko]), 0);
    step();
    s_rvalid[k] = 0; m_rready[g] = 0;
    #1;
    chk("done_rvalid", 32'(m_rvalid[g]), 0);
    chk("done_no_grant_c", 32'(s_arvalid[0]), 0);
    chk("done_no_grant_m", 32'(s_arvalid[1]), 0);
  endtask
  initial begin
    do_reset();
    chk("rst_sc_arvalid", 32'(s_arvalid[0]), 0);
    chk("rst_sm_arvalid", 32'(s_arvalid[1]), 0);
    chk("rst_sc_araddr", s_araddr[0], 0);
    chk("rst_sm_araddr", s_araddr[1], 0);
    chk("rst_m0_arready", 32'(m_arready[0]), 0);
    chk("rst_m1_rvalid", 32'(m_rvalid[1]), 0);
    chk("rst_m0_rdata", m_rdata[0], 0);
    chk("rst_m0_rresp", 32'(m_rresp[0]), 0);
    chk("rst_sm_rready", 32'(s_rready[1]), 0);
    request(0, 32'h8000_0000); step(); serve(0, 1, 32'h1234_5678, 2'b00, 2, 0);
    request(1, 32'ha000_004c); step(); serve(1, 0, 32'h0000_0001, 2'b00, 0, 0);
    request(1, 32'ha000_0050); step(); serve(1, 1, 32'hdead_0050, 2'b10, 0, 0);
    request(1, 32'ha000_0047); step(); serve(1, 1, 32'hdead_0047, 2'b11, 1, 0);
    request(0, 32'ha000_0048); step(); serve(0, 0, 32'hcafe_0048, 2'b00, 0, 0);
    request(0, 32'hffff_fffc); step(); serve(0, 1, 32'h0bad_fffc, 2'b00, 0, 0);
    request(0, 32'h8000_0010); step(); serve(0, 1, 32'h5555_aaaa, 2'b01, 0, 5);
    do_reset();
    request(0, 32'h8000_0100); request(1, 32'h8000_0200);
    step(); serve(0, 1, 32'h0000_0100, 2'b00, 0, 0);
    step(); serve(1, 1, 32'h0000_0200, 2'b00, 0, 0);
    request(0, 32'ha000_004c); request(1, 32'h8000_0300);
    step(); serve(0, 0, 32'h0000_0300, 2'b00, 0, 0);
    step(); serve(1, 1, 32'h0000_0400, 2'b00, 0, 0);
    request(0, 32'h8000_0400); step();
    chk("pre_rst_addr", 32'(s_arvalid[1]), 1);
    reset = 1; m_arvalid[0] = 0; step(); reset = 0;
    chk("rst_addr_sm_arvalid", 32'(s_arvalid[1]), 0);
    chk("rst_addr_m0_arready", 32'(m_arready[0]), 0);
    step();
    chk("rst_addr_idle", 32'(s_arvalid[1]), 0);
    request(0, 32'h8000_0500); step();
    s_arready[1] = 1; step();
    s_arready[1] = 0; m_arvalid[0] = 0; s_rvalid[1] = 1; s_rdata[1] = 32'h7777_7777; m_rready[0] = 1;
    #1;
    chk("pre_rst_data", 32'(m_rvalid[0]), 1);
    reset = 1;
    step();
    chk("rst_data_m0_rvalid", 32'(m_rvalid[0]), 0);
    chk("rst_data_m0_rdata", m_rdata[0], 0);
    chk("rst_data_sm_rready", 32'(s_rready[1]), 0);
    reset = 0; s_rvalid[1] = 0; m_rready[0] = 0;
    request(1, 32'h8000_0600); step(); serve(1, 1, 32'h6666_0600, 2'b00, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
